seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
- Parametrised, time-multiplexed seven-segment display driver for the board's 8-digit common-anode display.
- Captures a binary value on a load strobe and shows it in hex or unsigned decimal; decimal uses an iterative shift-add-3 (double-dabble) converter.
- Scans one digit per refresh slot, with optional leading-zero blanking.
- Sits between switch/ALU result logic and the AN/segment pins.

Parameters:
- NUM_DIGITS, 8, digits scanned (1..8).
- BIN_W, 16, width of VALUE; must satisfy BIN_W <= 4*NUM_DIGITS.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  asynchronous active-low reset.
- VALUE  in  BIN_W  unsigned value to display.
- LOAD  in  1  single-cycle capture strobe.
- MODE_DEC  in  1  1 = decimal, 0 = hex; sampled with LOAD.
- BLANK_LZ  in  1  1 = blank leading zeros; sampled live.
- BUSY  out  1  high while a capture/conversion is in progress.
- AN  out  NUM_DIGITS  digit enables, active low; AN[0] is the rightmost digit.
- OUT  out  7  segments, active low, OUT[6]=a … OUT[0]=g.

Behaviour:
- Reset is asynchronous on CPU_RESETN low. All of the following hold until release:
  - AN all 1s, OUT=7'b1111111, BUSY=0.
  - Display digit register all 0, overflow flag 0.
  - Scan index 0, divider 0.
  - Any conversion is aborted.
- FSM states: IDLE, HEX_LD, CONV, COMMIT.
- IDLE:
  - LOAD=1 latches VALUE and MODE_DEC.
  - MODE_DEC=0 -> HEX_LD; MODE_DEC=1 -> CONV.
  - LOAD is ignored whenever BUSY=1.
- HEX_LD (1 cycle):
  - Staging digits = VALUE zero-extended to 4*NUM_DIGITS, nibble k -> digit k.
  - Next state COMMIT.
- CONV (exactly BIN_W cycles), per cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then the {BCD, shift} register shifts left 1, MSB of VALUE first.
  - Iteration counter width is clog2(BIN_W+1).
  - Overflow flag is set at capture if VALUE >= 10^NUM_DIGITS (constant compare).
  - After the last iteration -> COMMIT.
- COMMIT (1 cycle):
  - The display register and overflow flag are copied atomically from staging.
  - Next state IDLE.
  - The scan never shows a partially converted value.
- BUSY:
  - 1 from the cycle after LOAD through the COMMIT cycle inclusive.
  - Hex mode: BUSY high 2 cycles; decimal mode: BIN_W+1 cycles.
  - New digits are visible on OUT at the first scan update after COMMIT.
- Scan:
  - Divider counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, scan index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
- AN/OUT are registered and reflect scan index one cycle after it changes. AN has exactly one 0, at bit = index.
- Glyphs:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111.
  - 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
  - Dash 1111110, blank 1111111.
- Overflow (decimal only): every digit shows dash.
- Leading-zero blanking:
  - With BLANK_LZ=1, a digit whose index is above the highest nonzero digit shows blank.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - BLANK_LZ has no effect on overflow dashes.
- Simultaneous events:
  - LOAD in the COMMIT cycle is ignored.
  - A scan wrap coinciding with COMMIT displays the old digit for that slot.
  - Reset mid-CONV returns to IDLE with a cleared display.

Test Plan:
- Reset, REFRESH_DIV=4, NUM_DIGITS=8 -> AN=8'b11111110, OUT=7'b0000001 after reset release. AN rotates 11111110 -> 11111101 every 4 cycles and wraps to 11111110 after digit 7.
- MODE_DEC=0, VALUE=16'hBEEF, LOAD -> BUSY high 2 cycles. Digits 0..3 show F,E,E,b (0111000, 0110000, 0110000, 1100000); digits 4..7 show "0".
- MODE_DEC=1, VALUE=16'd65535, LOAD -> BUSY high exactly 17 cycles. Digits 0..4 show 5,3,5,5,6; with BLANK_LZ=1, digits 5..7 show 1111111.
- NUM_DIGITS=4, BIN_W=16, decimal VALUE=12000 -> all 4 digits 1111110. Then VALUE=9999 -> 9,9,9,9 with no dashes.
- Decimal VALUE=0, BLANK_LZ=1 -> digit 0 shows 0000001, digits 1..7 blank. Pulse LOAD again mid-CONV with VALUE=7 -> ignored, display stays 0.
- Start conversion of 1234, assert CPU_RESETN=0 at iteration 8 -> AN all 1s, BUSY=0 immediately. After release the display shows all "0"; a new LOAD of 1234 shows 4,3,2,1.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment driver: captures a value on LOAD, converts it to hex or BCD
// (shift-add-3), and scans one active-low digit per refresh slot.
//
// state  | meaning
// IDLE   | waiting for LOAD
// HEX_LD | copy captured value into staging nibbles
// CONV   | one double-dabble iteration per cycle, BIN_W cycles
// COMMIT | staging digits + overflow copied to the display register
module seg7_scan_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int BIN_W       = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic [BIN_W-1:0]      VALUE,
    input  logic                  LOAD,
    input  logic                  MODE_DEC,
    input  logic                  BLANK_LZ,
    output logic                  BUSY,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            OUT
);
    localparam int DW   = 4 * NUM_DIGITS;
    localparam int IW   = $clog2(BIN_W + 1);
    localparam int DIVW = $clog2(REFRESH_DIV);
    localparam int IXW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, HEX_LD, CONV, COMMIT} state_t;

    state_t                  state, state_nxt;
    logic [BIN_W-1:0]        shift_q;
    logic [DW-1:0]           bcd_q, bcd_adj, disp_q;
    logic [DW+BIN_W-1:0]     dd_next;
    logic [IW-1:0]           iter_q;
    logic                    ovf_stage, ovf_q;
    logic [DIVW-1:0]         div_q;
    logic [IXW-1:0]          idx_q;
    logic                    upd_q, wrap;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              out_q, seg_cur;
    logic [3:0]              cur_digit;
    logic                    lz_blank;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != IDLE);
        case (state)
            IDLE:    if (LOAD) state_nxt = MODE_DEC ? CONV : HEX_LD;
            HEX_LD:  state_nxt = COMMIT;
            CONV:    if (iter_q == IW'(1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        dd_next = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            ovf_stage <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (LOAD) begin
                    shift_q   <= VALUE;
                    bcd_q     <= '0;
                    iter_q    <= IW'(BIN_W);
                    ovf_stage <= MODE_DEC && (64'(VALUE) >= DEC_LIMIT);
                end
                HEX_LD: bcd_q <= DW'(shift_q);
                CONV: begin
                    bcd_q   <= dd_next[DW+BIN_W-1:BIN_W];
                    shift_q <= dd_next[BIN_W-1:0];
                    iter_q  <= iter_q - 1'b1;
                end
                COMMIT: begin
                    disp_q <= bcd_q;
                    ovf_q  <= ovf_stage;
                end
                default: ;
            endcase
        end
    end

    // Digits at or above the current index all zero -> leading zero (digit 0 exempt).
    always_comb begin
        cur_digit = disp_q[{idx_q, 2'b00} +: 4];
        lz_blank  = BLANK_LZ && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
        if (ovf_q)         seg_cur = SEG_DASH;
        else if (lz_blank) seg_cur = SEG_BLANK;
        else               seg_cur = glyph(cur_digit);
    end

    assign wrap = (div_q == DIVW'(REFRESH_DIV - 1));

    // Outputs reload only on a scan update, so a COMMIT landing with the update keeps the old glyph.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_q <= '0;
            idx_q <= '0;
            upd_q <= 1'b1;
            an_q  <= '1;
            out_q <= SEG_BLANK;
        end else begin
            upd_q <= wrap;
            if (wrap) begin
                div_q <= '0;
                idx_q <= (idx_q == IXW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (upd_q) begin
                an_q  <= ~(NUM_DIGITS'(1) << idx_q);
                out_q <= seg_cur;
            end
        end
    end

    assign AN  = an_q;
    assign OUT = out_q;
endmodule
